// File: rtl/mem_wb_stage_pkg.sv
// Shared pipeline package: word and register-address widths, the load-latency
// ceiling, and the state type for the MEM-stage load FSM.
// Optional build macro used by mem_wb_stage: MISALIGN_TRAP_EN.
package pipe_pkg;

    localparam int WORD_W      = 32;
    localparam int REG_AW      = 5;
    localparam int MEM_LAT_MAX = 15;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/mem_wb_stage_if.sv
// Signal bundle between the EX/MEM register, the MEM stage and the writeback
// logic. The slave modport is the MEM stage itself; the master modport is the
// surrounding pipeline (EX/MEM driver plus hazard/PC/writeback consumers).
interface mem_wb_stage_if;
    import pipe_pkg::*;

    // Control and data from EX/MEM
    logic                RegWrite_i;
    logic                MemtoReg_i;
    logic                Branch_i;
    logic                MemRead_i;
    logic                MemWrite_i;
    logic                ALUzero_i;
    logic [WORD_W-1:0]   Adderdata_i;
    logic [WORD_W-1:0]   ALUdata_i;
    logic [WORD_W-1:0]   MemWdata_i;
    logic [REG_AW-1:0]   RegWaddr_i;

    // Branch resolution, hazard and MEM/WB outputs
    logic                PCSrc_o;
    logic [WORD_W-1:0]   BranchAddr_o;
    logic                stall_o;
    logic                RegWrite_o;
    logic                MemtoReg_o;
    logic [WORD_W-1:0]   MemRdata_o;
    logic [WORD_W-1:0]   ALUdata_o;
    logic [REG_AW-1:0]   RegWaddr_o;
    logic                misalign_o;

    modport master (
        output RegWrite_i, MemtoReg_i, Branch_i, MemRead_i, MemWrite_i,
        output ALUzero_i, Adderdata_i, ALUdata_i, MemWdata_i, RegWaddr_i,
        input  PCSrc_o, BranchAddr_o, stall_o, RegWrite_o, MemtoReg_o,
        input  MemRdata_o, ALUdata_o, RegWaddr_o, misalign_o
    );

    modport slave (
        input  RegWrite_i, MemtoReg_i, Branch_i, MemRead_i, MemWrite_i,
        input  ALUzero_i, Adderdata_i, ALUdata_i, MemWdata_i, RegWaddr_i,
        output PCSrc_o, BranchAddr_o, stall_o, RegWrite_o, MemtoReg_o,
        output MemRdata_o, ALUdata_o, RegWaddr_o, misalign_o
    );

endinterface

// File: rtl/mem_wb_stage_data_mem.sv
// Word-addressed data memory: synchronous write, combinational read.
// The array is deliberately not reset; software (or the bench) initialises it.
module data_mem
    import pipe_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [WORD_W-1:0] i_wdata,
    output logic [WORD_W-1:0] o_rdata
);

    logic [WORD_W-1:0] r_mem [DEPTH];

    // Store port: one word written on the clock edge when enabled
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage plus MEM/WB pipeline register.
// Resolves branches, owns the data memory, stretches loads to MEM_LAT cycles
// by stalling the upstream stages, and feeds the writeback mux.
// Optional build macro: MISALIGN_TRAP_EN -- when defined, loads/stores with a
// non-word-aligned address are suppressed and raise a one-cycle misalign_o.
module mem_wb_stage
    import pipe_pkg::*;
#(
    parameter  int DEPTH   = 256,
    parameter  int MEM_LAT = 2,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic         clk_i,
    input  logic         start_i,
    mem_wb_stage_if.slave bus
);

    // Counter preload so that WAIT lasts MEM_LAT-1 cycles including the capture cycle
    localparam logic [3:0] CNT_INIT = (MEM_LAT > 1) ? 4'(MEM_LAT - 2) : 4'd0;
    localparam bit         LOAD_STALLS = (MEM_LAT > 1);

    state_t            r_state;
    state_t            w_nextState;
    logic [3:0]        r_cnt;
    logic [3:0]        w_nextCnt;
    logic              w_stall;
    logic              w_capture;
    logic              w_isLoad;
    logic              w_memWe;
    logic              w_misalign;
    logic [ADDR_W-1:0] w_index;
    logic [WORD_W-1:0] w_rdata;

    logic              r_regWrite;
    logic              r_memtoReg;
    logic [WORD_W-1:0] r_memRdata;
    logic [WORD_W-1:0] r_aluData;
    logic [REG_AW-1:0] r_regWaddr;

    // A store wins when both MemRead_i and MemWrite_i are asserted
    assign w_isLoad = bus.MemRead_i & ~bus.MemWrite_i;
    assign w_index  = bus.ALUdata_i[ADDR_W+1:2];

`ifdef MISALIGN_TRAP_EN
    assign w_misalign = (bus.MemRead_i | bus.MemWrite_i) & (bus.ALUdata_i[1:0] != 2'b00)
                        & (r_state == IDLE);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_memWe = (r_state == IDLE) & bus.MemWrite_i & ~w_misalign;

    data_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .i_clk   (clk_i),
        .i_we    (w_memWe),
        .i_addr  (w_index),
        .i_wdata (bus.MemWdata_i),
        .o_rdata (w_rdata)
    );

    // Branch resolution is purely combinational and ignores the stall
    assign bus.PCSrc_o      = bus.Branch_i & bus.ALUzero_i;
    assign bus.BranchAddr_o = bus.Adderdata_i;

    // Load FSM: decide stall, capture and the next state/counter value
    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        w_stall     = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_isLoad && !w_misalign && LOAD_STALLS) begin
                    w_stall     = 1'b1;
                    w_nextState = WAIT;
                    w_nextCnt   = CNT_INIT;
                end else begin
                    w_capture = 1'b1;
                end
            end
            WAIT: begin
                if (r_cnt != 4'd0) begin
                    w_stall   = 1'b1;
                    w_nextCnt = r_cnt - 4'd1;
                end else begin
                    w_capture   = 1'b1;
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
                w_nextCnt   = 4'd0;
            end
        endcase
    end

    // Stall is forced low while reset is held so an aborted load releases upstream at once
    assign bus.stall_o = w_stall & start_i;

    // FSM state and latency counter registers
    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_nextCnt;
        end
    end

    // MEM/WB register: capture on non-stalled cycles, otherwise insert a bubble
    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            r_regWrite <= 1'b0;
            r_memtoReg <= 1'b0;
            r_memRdata <= '0;
            r_aluData  <= '0;
            r_regWaddr <= '0;
        end else if (w_capture) begin
            r_regWrite <= bus.RegWrite_i & ~w_misalign;
            r_memtoReg <= bus.MemtoReg_i;
            r_memRdata <= w_isLoad ? w_rdata : '0;
            r_aluData  <= bus.ALUdata_i;
            r_regWaddr <= bus.RegWaddr_i;
        end else begin
            r_regWrite <= 1'b0;
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic r_misalign;

    // One-cycle trap pulse for a misaligned access seen in IDLE
    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_capture & w_misalign;
        end
    end

    assign bus.misalign_o = r_misalign;
`else
    assign bus.misalign_o = 1'b0;
`endif

    assign bus.RegWrite_o = r_regWrite;
    assign bus.MemtoReg_o = r_memtoReg;
    assign bus.MemRdata_o = r_memRdata;
    assign bus.ALUdata_o  = r_aluData;
    assign bus.RegWaddr_o = r_regWaddr;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed testbench for mem_wb_stage with two instances: MEM_LAT=2 (dut2)
// and MEM_LAT=4 (dut4). Honours MISALIGN_TRAP_EN when it is defined.
module tb_mem_wb_stage;

    logic clk;
    logic start2;
    logic start4;
    int   checks   = 0;
    int   failures = 0;

    mem_wb_stage_if bus2();
    mem_wb_stage_if bus4();

    mem_wb_stage #(.DEPTH(256), .MEM_LAT(2)) dut2 (
        .clk_i   (clk),
        .start_i (start2),
        .bus     (bus2.slave)
    );

    mem_wb_stage #(.DEPTH(256), .MEM_LAT(4)) dut4 (
        .clk_i   (clk),
        .start_i (start4),
        .bus     (bus4.slave)
    );

    // Free-running clock, posedges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Return dut2 inputs to an idle bubble
    task automatic clear2();
        bus2.RegWrite_i  = 1'b0;
        bus2.MemtoReg_i  = 1'b0;
        bus2.Branch_i    = 1'b0;
        bus2.MemRead_i   = 1'b0;
        bus2.MemWrite_i  = 1'b0;
        bus2.ALUzero_i   = 1'b0;
        bus2.Adderdata_i = 32'h0;
        bus2.ALUdata_i   = 32'h0;
        bus2.MemWdata_i  = 32'h0;
        bus2.RegWaddr_i  = 5'd0;
    endtask

    // Return dut4 inputs to an idle bubble
    task automatic clear4();
        bus4.RegWrite_i  = 1'b0;
        bus4.MemtoReg_i  = 1'b0;
        bus4.Branch_i    = 1'b0;
        bus4.MemRead_i   = 1'b0;
        bus4.MemWrite_i  = 1'b0;
        bus4.ALUzero_i   = 1'b0;
        bus4.Adderdata_i = 32'h0;
        bus4.ALUdata_i   = 32'h0;
        bus4.MemWdata_i  = 32'h0;
        bus4.RegWaddr_i  = 5'd0;
    endtask

    // Both instances held in reset: every registered output and stall must be 0
    task automatic test_reset();
        logic [70:0] obs;
        #2;
        start2 = 1'b0;
        start4 = 1'b0;
        #10;
        obs = {bus2.RegWrite_o, bus2.MemtoReg_o, bus2.MemRdata_o, bus2.ALUdata_o, bus2.RegWaddr_o};
        checks++;
        if (obs !== 71'h0) begin
            failures++;
            $display("[TB] FAIL reset_outs2 got=%h exp=0", obs);
        end
        checks++;
        if ({bus2.stall_o, bus2.misalign_o, bus2.PCSrc_o} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL reset_flags2 got=%b exp=000", {bus2.stall_o, bus2.misalign_o, bus2.PCSrc_o});
        end
        obs = {bus4.RegWrite_o, bus4.MemtoReg_o, bus4.MemRdata_o, bus4.ALUdata_o, bus4.RegWaddr_o};
        checks++;
        if (obs !== 71'h0 || bus4.stall_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_outs4 got=%h stall=%b exp=0", obs, bus4.stall_o);
        end
        @(posedge clk);
        #1;
        start2 = 1'b1;
        start4 = 1'b1;
    endtask

    // Store DEADBEEF to 0x10 then load it back into r5 with a one-cycle stall
    task automatic test_store_load();
        bus2.MemWrite_i = 1'b1;
        bus2.ALUdata_i  = 32'h10;
        bus2.MemWdata_i = 32'hDEADBEEF;
        #1;
        checks++;
        if (bus2.stall_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL sl_store_stall got=%b exp=0", bus2.stall_o);
        end
        tick();
        checks++;
        if ({bus2.RegWrite_o, bus2.ALUdata_o} !== {1'b0, 32'h10}) begin
            failures++;
            $display("[TB] FAIL sl_store_cap got=%b/%h exp=0/00000010", bus2.RegWrite_o, bus2.ALUdata_o);
        end
        clear2();
        bus2.MemRead_i  = 1'b1;
        bus2.RegWrite_i = 1'b1;
        bus2.MemtoReg_i = 1'b1;
        bus2.RegWaddr_i = 5'd5;
        bus2.ALUdata_i  = 32'h10;
        #1;
        checks++;
        if (bus2.stall_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL sl_load_stall got=%b exp=1", bus2.stall_o);
        end
        tick();
        checks++;
        if ({bus2.RegWrite_o, bus2.stall_o} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL sl_bubble got=rw%b stall%b exp=rw0 stall0", bus2.RegWrite_o, bus2.stall_o);
        end
        tick();
        checks++;
        if ({bus2.RegWrite_o, bus2.MemtoReg_o, bus2.MemRdata_o, bus2.RegWaddr_o} !==
            {1'b1, 1'b1, 32'hDEADBEEF, 5'd5}) begin
            failures++;
            $display("[TB] FAIL sl_capture got=rw%b m2r%b data=%h rd=%0d exp=rw1 m2r1 data=deadbeef rd=5",
                     bus2.RegWrite_o, bus2.MemtoReg_o, bus2.MemRdata_o, bus2.RegWaddr_o);
        end
        clear2();
    endtask

    // Combinational branch resolution
    task automatic test_branch();
        bus2.Branch_i    = 1'b1;
        bus2.ALUzero_i   = 1'b1;
        bus2.Adderdata_i = 32'h40;
        #1;
        checks++;
        if ({bus2.PCSrc_o, bus2.BranchAddr_o} !== {1'b1, 32'h40}) begin
            failures++;
            $display("[TB] FAIL br_taken got=%b/%h exp=1/00000040", bus2.PCSrc_o, bus2.BranchAddr_o);
        end
        bus2.ALUzero_i = 1'b0;
        #1;
        checks++;
        if (bus2.PCSrc_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL br_notzero got=%b exp=0", bus2.PCSrc_o);
        end
        bus2.Branch_i  = 1'b0;
        bus2.ALUzero_i = 1'b1;
        #1;
        checks++;
        if (bus2.PCSrc_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL br_nobranch got=%b exp=0", bus2.PCSrc_o);
        end
        clear2();
        tick();
    endtask

    // MEM_LAT=4: two loads in a row, stall pattern 1,1,1,0,1,1,1,0
    task automatic test_back_to_back();
        logic expStall;
        logic expRw;
        bus4.MemWrite_i = 1'b1;
        bus4.ALUdata_i  = 32'h20;
        bus4.MemWdata_i = 32'h11111111;
        tick();
        bus4.ALUdata_i  = 32'h24;
        bus4.MemWdata_i = 32'h22222222;
        tick();
        clear4();
        for (int i = 0; i < 8; i++) begin
            if (i == 0) begin
                bus4.MemRead_i  = 1'b1;
                bus4.RegWrite_i = 1'b1;
                bus4.MemtoReg_i = 1'b1;
                bus4.ALUdata_i  = 32'h20;
                bus4.RegWaddr_i = 5'd7;
            end
            if (i == 4) begin
                bus4.ALUdata_i  = 32'h24;
                bus4.RegWaddr_i = 5'd8;
            end
            #1;
            expStall = ((i % 4) != 3);
            checks++;
            if (bus4.stall_o !== expStall) begin
                failures++;
                $display("[TB] FAIL b2b_stall[%0d] got=%b exp=%b", i, bus4.stall_o, expStall);
            end
            tick();
            expRw = ((i % 4) == 3);
            checks++;
            if (bus4.RegWrite_o !== expRw) begin
                failures++;
                $display("[TB] FAIL b2b_regwrite[%0d] got=%b exp=%b", i, bus4.RegWrite_o, expRw);
            end
            if (i == 3) begin
                checks++;
                if ({bus4.MemRdata_o, bus4.RegWaddr_o} !== {32'h11111111, 5'd7}) begin
                    failures++;
                    $display("[TB] FAIL b2b_cap1 got=%h rd=%0d exp=11111111 rd=7", bus4.MemRdata_o, bus4.RegWaddr_o);
                end
            end
            if (i == 7) begin
                checks++;
                if ({bus4.MemRdata_o, bus4.RegWaddr_o} !== {32'h22222222, 5'd8}) begin
                    failures++;
                    $display("[TB] FAIL b2b_cap2 got=%h rd=%0d exp=22222222 rd=8", bus4.MemRdata_o, bus4.RegWaddr_o);
                end
            end
        end
        clear4();
    endtask

    // MEM_LAT=4: reset during the second WAIT cycle, then a full-length retry
    task automatic test_reset_mid_load();
        logic [70:0] obs;
        logic        expStall;
        logic        expRw;
        bus4.MemRead_i  = 1'b1;
        bus4.RegWrite_i = 1'b1;
        bus4.MemtoReg_i = 1'b1;
        bus4.ALUdata_i  = 32'h20;
        bus4.RegWaddr_i = 5'd9;
        tick();
        tick();
        checks++;
        if (bus4.stall_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rst_mid_pre got=%b exp=1", bus4.stall_o);
        end
        start4 = 1'b0;
        #1;
        checks++;
        if (bus4.stall_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rst_mid_stall got=%b exp=0", bus4.stall_o);
        end
        obs = {bus4.RegWrite_o, bus4.MemtoReg_o, bus4.MemRdata_o, bus4.ALUdata_o, bus4.RegWaddr_o};
        checks++;
        if (obs !== 71'h0) begin
            failures++;
            $display("[TB] FAIL rst_mid_outs got=%h exp=0", obs);
        end
        tick();
        start4 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            expStall = (i != 3);
            checks++;
            if (bus4.stall_o !== expStall) begin
                failures++;
                $display("[TB] FAIL rst_retry_stall[%0d] got=%b exp=%b", i, bus4.stall_o, expStall);
            end
            tick();
            expRw = (i == 3);
            checks++;
            if (bus4.RegWrite_o !== expRw) begin
                failures++;
                $display("[TB] FAIL rst_retry_rw[%0d] got=%b exp=%b", i, bus4.RegWrite_o, expRw);
            end
        end
        checks++;
        if ({bus4.MemRdata_o, bus4.RegWaddr_o} !== {32'h11111111, 5'd9}) begin
            failures++;
            $display("[TB] FAIL rst_retry_cap got=%h rd=%0d exp=11111111 rd=9", bus4.MemRdata_o, bus4.RegWaddr_o);
        end
        clear4();
    endtask

    // Address 0x400 wraps onto word 0 with DEPTH=256
    task automatic test_wrap();
        bus2.MemWrite_i = 1'b1;
        bus2.ALUdata_i  = 32'h400;
        bus2.MemWdata_i = 32'h1234;
        tick();
        clear2();
        bus2.MemRead_i  = 1'b1;
        bus2.RegWrite_i = 1'b1;
        bus2.MemtoReg_i = 1'b1;
        bus2.ALUdata_i  = 32'h0;
        bus2.RegWaddr_i = 5'd12;
        #1;
        checks++;
        if (bus2.stall_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL wrap_stall got=%b exp=1", bus2.stall_o);
        end
        tick();
        tick();
        checks++;
        if ({bus2.RegWrite_o, bus2.MemRdata_o, bus2.RegWaddr_o} !== {1'b1, 32'h1234, 5'd12}) begin
            failures++;
            $display("[TB] FAIL wrap_data got=rw%b %h rd=%0d exp=rw1 00001234 rd=12",
                     bus2.RegWrite_o, bus2.MemRdata_o, bus2.RegWaddr_o);
        end
        clear2();
    endtask

    // Misaligned accesses: trapped when the macro is defined, otherwise low bits ignored
    task automatic test_misalign();
`ifdef MISALIGN_TRAP_EN
        bus2.MemWrite_i = 1'b1;
        bus2.ALUdata_i  = 32'h13;
        bus2.MemWdata_i = 32'hCAFEF00D;
        #1;
        checks++;
        if (bus2.stall_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mis_store_stall got=%b exp=0", bus2.stall_o);
        end
        tick();
        checks++;
        if (bus2.misalign_o !== 1'b1) begin
            failures++;
            $display("[TB] FAIL mis_store_pulse got=%b exp=1", bus2.misalign_o);
        end
        clear2();
        tick();
        checks++;
        if (bus2.misalign_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mis_pulse_end got=%b exp=0", bus2.misalign_o);
        end
        bus2.MemRead_i  = 1'b1;
        bus2.RegWrite_i = 1'b1;
        bus2.ALUdata_i  = 32'h10;
        bus2.RegWaddr_i = 5'd3;
        tick();
        tick();
        checks++;
        if (bus2.MemRdata_o !== 32'hDEADBEEF) begin
            failures++;
            $display("[TB] FAIL mis_mem_unchanged got=%h exp=deadbeef", bus2.MemRdata_o);
        end
        bus2.ALUdata_i  = 32'h13;
        bus2.RegWaddr_i = 5'd4;
        #1;
        checks++;
        if (bus2.stall_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mis_load_stall got=%b exp=0", bus2.stall_o);
        end
        tick();
        checks++;
        if ({bus2.RegWrite_o, bus2.misalign_o} !== 2'b01) begin
            failures++;
            $display("[TB] FAIL mis_load_cap got=rw%b mis%b exp=rw0 mis1", bus2.RegWrite_o, bus2.misalign_o);
        end
        clear2();
        tick();
`else
        bus2.MemRead_i  = 1'b1;
        bus2.RegWrite_i = 1'b1;
        bus2.ALUdata_i  = 32'h13;
        bus2.RegWaddr_i = 5'd4;
        #1;
        checks++;
        if ({bus2.stall_o, bus2.misalign_o} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL lowbits_stall got=stall%b mis%b exp=stall1 mis0", bus2.stall_o, bus2.misalign_o);
        end
        tick();
        tick();
        checks++;
        if ({bus2.RegWrite_o, bus2.MemRdata_o, bus2.misalign_o} !== {1'b1, 32'hDEADBEEF, 1'b0}) begin
            failures++;
            $display("[TB] FAIL lowbits_load got=rw%b %h mis%b exp=rw1 deadbeef mis0",
                     bus2.RegWrite_o, bus2.MemRdata_o, bus2.misalign_o);
        end
        clear2();
`endif
    endtask

    // Test sequence
    initial begin
        start2 = 1'b1;
        start4 = 1'b1;
        clear2();
        clear4();
        test_reset();
        test_store_load();
        test_branch();
        test_back_to_back();
        test_reset_mid_load();
        test_wrap();
        test_misalign();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run can never hang
    initial begin
        #50000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM stage of the 5-stage pipeline, fed directly by the EX/MEM register outputs.
- Holds the data memory and resolves branches (PCSrc = Branch & zero).
- Models multi-cycle load latency with a stall back to IF/ID/EX/MEM.
- Contains the MEM/WB pipeline register that drives the writeback mux.

Parameters:
- DEPTH, 256: data memory depth in 32-bit words; power of two.
- MEM_LAT, 2: load latency in cycles; legal range 1..15.
- ADDR_W, $clog2(DEPTH): word-address width; derived, not overridden.

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- start_i  in  1  asynchronous active-low reset.
- RegWrite_i, MemtoReg_i, Branch_i, MemRead_i, MemWrite_i  in  1 each  control from EX/MEM.
- ALUzero_i  in  1  ALU zero flag.
- Adderdata_i  in  32  branch target.
- ALUdata_i  in  32  ALU result / byte address.
- MemWdata_i  in  32  store data.
- RegWaddr_i  in  5  destination register.
- PCSrc_o  out  1  branch taken.
- BranchAddr_o  out  32  branch target to PC mux.
- stall_o  out  1  freeze PC, IF/ID, ID/EX, EX/MEM this cycle.
- RegWrite_o, MemtoReg_o  out  1 each  MEM/WB control.
- MemRdata_o  out  32  load data.
- ALUdata_o  out  32  passed-through ALU result.
- RegWaddr_o  out  5  destination register.
- misalign_o  out  1  alignment trap pulse (see Optional Feature).

Behaviour:
- Reset (start_i low, asynchronous): state IDLE, cnt 0, all registered outputs 0. Memory contents are not reset; the bench preloads them.
- Memory word index: ALUdata_i[ADDR_W+1:2]. Upper bits are ignored, so addresses wrap modulo DEPTH words.
- PCSrc_o = Branch_i & ALUzero_i, combinational. BranchAddr_o = Adderdata_i. Both are independent of stall.
- Store: MemWrite_i high in IDLE writes MemWdata_i on the posedge. Single cycle, no stall.
- MemRead_i and MemWrite_i both high: treated as a store only.
- FSM states: IDLE, WAIT; 4-bit down-counter cnt.
- IDLE, MemRead_i=1, MEM_LAT>1:
  - stall_o=1; next state WAIT, cnt<=MEM_LAT-2.
  - MEM/WB inserts a bubble: RegWrite_o<=0, other outputs hold.
- WAIT, cnt!=0: stall_o=1, cnt decrements, bubble again.
- WAIT, cnt==0: stall_o=0, MEM/WB captures, next state IDLE.
- MEM_LAT==1: loads never stall or enter WAIT.
- Every load therefore occupies exactly MEM_LAT cycles, with stall_o high for the first MEM_LAT-1.
- Upstream holds its inputs stable while stall_o is high. Inputs sampled during WAIT are assumed unchanged.
- Capture (any non-stalled cycle):
  - RegWrite_o, MemtoReg_o, ALUdata_o, RegWaddr_o <= the corresponding inputs.
  - MemRdata_o <= mem[index] if MemRead_i, else 0.
- Back-to-back loads: the second load starts in IDLE on the cycle after capture and stalls again. There is no overlap.
- Reset asserted in WAIT: abort to IDLE. Read data is discarded, stall_o drops immediately.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- When defined, a load or store with ALUdata_i[1:0]!=0 in IDLE:
  - no memory write and no stall;
  - MEM/WB captures with RegWrite_o<=0;
  - misalign_o is a one-cycle registered pulse.
- When undefined: low address bits are ignored; misalign_o is tied to 0.

Decomposition:
- Shared package pipe_pkg:
  - WORD_W=32, REG_AW=5;
  - state enum {IDLE, WAIT};
  - MEM_LAT_MAX=15.
- One sub-module, data_mem: DEPTH x 32 array, synchronous write, combinational read. No reset on the array.

Test Plan:
- Store/load, MEM_LAT=2: store 0xDEADBEEF to 0x10, then load 0x10, rd=5.
  -> stall_o high for 1 cycle; next cycle RegWrite_o=1, MemtoReg_o=1, MemRdata_o=0xDEADBEEF, RegWaddr_o=5.
- Branch: Branch_i=1, ALUzero_i=1, Adderdata_i=0x40 -> PCSrc_o=1, BranchAddr_o=0x40 the same cycle. With ALUzero_i=0 -> PCSrc_o=0.
- MEM_LAT=4, two consecutive loads -> stall_o pattern 1,1,1,0,1,1,1,0. Two captures, with RegWrite_o=0 on all stalled cycles.
- Reset mid-load: start_i low during the 2nd WAIT cycle (MEM_LAT=4) -> stall_o=0 and all outputs 0 immediately. Next load takes the full 4 cycles.
- Wrap-around, DEPTH=256: store 0x1234 to 0x400, load 0x000 -> MemRdata_o=0x1234.
- MISALIGN_TRAP_EN defined: store to 0x13 -> misalign_o pulses once, memory at word 4 unchanged. Load from 0x13 -> RegWrite_o=0, no stall.
